omen_fetch_queue: RTL and testbench

- Instruction-fetch front end for the 32-bit omen pipeline; sits upstream of decode and feeds it.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched words with their next-PC in a small FIFO and presents them to decode with a valid/ready handshake.
- A taken branch from EX/MEM redirects it; a redirect flushes every queued and in-flight instruction.

---
 rtl/omen_fetch_if.sv | 39 +++
 rtl/omen_fetch_queue.sv | 124 ++++++++++++
 tb/tb_omen_fetch_queue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/omen_fetch_if.sv
// omen_fetch_if: bus bundle between the omen fetch queue, the instruction
// memory and the decode stage.
//   imem_req / imem_addr  : read strobe and word address to instruction memory
//   imem_rdata            : word returned by memory one cycle after imem_req
//   id_valid / id_ready   : valid/ready handshake toward decode
//   id_ir / id_npc        : head instruction word and its next-PC
// modport master : the fetch queue (drives memory requests and decode outputs)
// modport slave  : the memory/decode side
interface omen_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_ir;
    logic [31:0]       id_npc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output id_valid,
        input  id_ready,
        output id_ir,
        output id_npc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  id_valid,
        output id_ready,
        input  id_ir,
        input  id_npc
    );
endinterface

// File: rtl/omen_fetch_queue.sv
// omen_fetch_queue: instruction-fetch front end of the 32-bit omen pipeline.
// Issues reads to a 1-cycle-latency synchronous instruction memory, buffers
// returned words together with their next-PC in a DEPTH-entry FIFO, and
// presents the FIFO head to decode over a valid/ready handshake. A taken
// branch (i_redirect_valid) flushes the FIFO, cancels the in-flight fetch and
// reloads the PC.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_fetch_en          : allow new fetches to issue
//   i_redirect_valid    : single-cycle taken-branch pulse
//   i_redirect_target   : branch target word address
//   bus (master)        : imem_req/imem_addr/imem_rdata and id_valid/id_ready/
//                         id_ir/id_npc (see omen_fetch_if)
//   o_pc_out            : address of the next fetch to issue
//   o_occupancy         : number of valid FIFO entries
// ADDR_W must be below 32 (id_npc zero-extends the address).
module omen_fetch_queue #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'hFFFF_FFFF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_fetch_en,
    input  logic                   i_redirect_valid,
    input  logic [ADDR_W-1:0]      i_redirect_target,
    omen_fetch_if.master           bus,
    output logic [ADDR_W-1:0]      o_pc_out,
    output logic [$clog2(DEPTH):0] o_occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0]    DEPTH_W  = (OCC_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0]  OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [31:0]       r_ir_mem  [DEPTH];
    logic [ADDR_W-1:0] r_npc_mem [DEPTH];

    logic              w_id_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [OCC_W:0]    w_pending;

    // Handshake qualifiers and the issue decision.
    always_comb begin
        w_id_valid = (r_occ != {OCC_W{1'b0}});
        // A redirect cycle neither consumes an entry nor accepts the returning word.
        w_pop      = w_id_valid & bus.id_ready & ~i_redirect_valid;
        w_push     = r_inflight & ~i_redirect_valid;
        // Slots already committed (queued + in flight) after this cycle's pop;
        // an issue is allowed only if that leaves room for its return.
        w_pending  = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight}
                   - {{OCC_W{1'b0}}, w_pop};
        w_issue    = i_fetch_en & ~i_redirect_valid & ~i_rst & (w_pending < DEPTH_W);
    end

    // Drive memory request, decode head and debug outputs.
    always_comb begin
        bus.imem_req  = w_issue;
        bus.imem_addr = r_pc;
        bus.id_valid  = w_id_valid;
        o_pc_out      = r_pc;
        o_occupancy   = r_occ;
        if (w_id_valid) begin
            bus.id_ir  = r_ir_mem[r_rd_ptr];
            bus.id_npc = {{(32-ADDR_W){1'b0}}, r_npc_mem[r_rd_ptr]};
        end else begin
            bus.id_ir  = NOP_WORD;
            bus.id_npc = 32'd0;
        end
    end

    // FIFO storage; contents are only meaningful below r_occ, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_ir_mem[r_wr_ptr]  <= bus.imem_rdata;
            r_npc_mem[r_wr_ptr] <= r_inflight_addr + ADDR_ONE;
        end
    end

    // PC, in-flight tracking, pointers and occupancy; reset beats redirect beats normal flow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc            <= {ADDR_W{1'b0}};
            r_inflight      <= 1'b0;
            r_inflight_addr <= {ADDR_W{1'b0}};
            r_wr_ptr        <= {PTR_W{1'b0}};
            r_rd_ptr        <= {PTR_W{1'b0}};
            r_occ           <= {OCC_W{1'b0}};
        end else if (i_redirect_valid) begin
            r_pc            <= i_redirect_target;
            r_inflight      <= 1'b0;
            r_wr_ptr        <= {PTR_W{1'b0}};
            r_rd_ptr        <= {PTR_W{1'b0}};
            r_occ           <= {OCC_W{1'b0}};
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc            <= r_pc + ADDR_ONE;
                r_inflight_addr <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: tb/tb_omen_fetch_queue.sv
// tb_omen_fetch_queue: directed self-checking bench for omen_fetch_queue.
// A behavioural 1-cycle-latency memory returns 32'h1000_0000 + address.
module tb_omen_fetch_queue;
    localparam int ADDR_W = 10;
    localparam logic [31:0] NOP = 32'hFFFF_FFFF;

    logic              clk;
    logic              rst;
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] pc_out;
    logic [2:0]        occupancy;

    int n_checks = 0;
    int n_errors = 0;

    omen_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    omen_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(4), .NOP_WORD(NOP)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_fetch_en        (fetch_en),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .bus               (bus),
        .o_pc_out          (pc_out),
        .o_occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + {22'd0, a};
    endfunction

    // Instruction memory: registered read, data valid the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= word_at(bus.imem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input int addr);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] n;
        a = ADDR_W'(addr);
        n = a + 10'd1;
        check_eq({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
        check_eq({tag, "_ir"}, bus.id_ir, word_at(a));
        check_eq({tag, "_npc"}, bus.id_npc, {22'd0, n});
    endtask

    // One reset edge; returns #1 into cycle 0 with fetch_en=1.
    task automatic do_reset(input logic ready);
        rst = 1'b1;
        redirect_valid = 1'b0;
        fetch_en = 1'b1;
        bus.id_ready = ready;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 10'd0;
        bus.id_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        tick();
        tick();

        // Reset state
        check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
        check_eq("rst_ir", bus.id_ir, NOP);
        check_eq("rst_npc", bus.id_npc, 32'd0);
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_pc", 32'(pc_out), 32'd0);
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);

        // Stream: first word visible in cycle 2, then one per cycle
        rst = 1'b0;
        fetch_en = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        check_eq("s_req_c0", 32'(bus.imem_req), 32'd1);
        check_eq("s_addr_c0", 32'(bus.imem_addr), 32'd0);
        tick();
        check_eq("s_valid_c1", 32'(bus.id_valid), 32'd0);
        tick();
        expect_head("s_c2", 0);
        for (int i = 1; i < 6; i++) begin
            tick();
            expect_head("s_seq", i);
        end
        check_eq("s_occ", 32'(occupancy), 32'd1);

        // Backpressure: fill, hold head, then drain in order
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c >= 4) check_eq("bp_req_full", 32'(bus.imem_req), 32'd0);
            tick();
        end
        check_eq("bp_occ", 32'(occupancy), 32'd4);
        check_eq("bp_req", 32'(bus.imem_req), 32'd0);
        expect_head("bp_hold", 0);
        bus.id_ready = 1'b1;
        #1;
        check_eq("bp_req_pop", 32'(bus.imem_req), 32'd1);
        for (int i = 0; i < 10; i++) begin
            expect_head("bp_drain", i);
            tick();
        end

        // Redirect with a fetch in flight
        do_reset(1'b1);
        tick();
        tick();
        expect_head("rd_c2", 0);
        tick();
        expect_head("rd_c3", 1);
        tick();
        expect_head("rd_c4", 2);
        tick();
        check_eq("rd_addr5", 32'(bus.imem_addr), 32'd5);
        redirect_valid = 1'b1;
        redirect_target = 10'h020;
        #1;
        check_eq("rd_req_cut", 32'(bus.imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("rd_occ", 32'(occupancy), 32'd0);
        check_eq("rd_valid", 32'(bus.id_valid), 32'd0);
        check_eq("rd_ir_nop", bus.id_ir, NOP);
        check_eq("rd_pc", 32'(pc_out), 32'h20);
        check_eq("rd_req", 32'(bus.imem_req), 32'd1);
        tick();
        check_eq("rd_valid_c7", 32'(bus.id_valid), 32'd0);
        tick();
        expect_head("rd_tgt", 32'h20);
        tick();
        expect_head("rd_tgt1", 32'h21);

        // Redirect with full FIFO and simultaneous pop
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) tick();
        check_eq("rf_occ_full", 32'(occupancy), 32'd4);
        bus.id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 10'h003;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("rf_occ", 32'(occupancy), 32'd0);
        check_eq("rf_valid", 32'(bus.id_valid), 32'd0);
        check_eq("rf_pc", 32'(pc_out), 32'd3);
        tick();
        tick();
        expect_head("rf_tgt", 3);
        tick();
        expect_head("rf_tgt1", 4);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_target = 10'h3FE;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("wr_pc", 32'(pc_out), 32'h3FE);
        tick();
        tick();
        expect_head("wr_3fe", 32'h3FE);
        tick();
        expect_head("wr_3ff", 32'h3FF);
        tick();
        expect_head("wr_000", 0);

        // Reset mid-operation with occupancy 3 and a fetch in flight
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) tick();
        check_eq("mr_occ3", 32'(occupancy), 32'd3);
        rst = 1'b1;
        tick();
        check_eq("mr_occ", 32'(occupancy), 32'd0);
        check_eq("mr_valid", 32'(bus.id_valid), 32'd0);
        check_eq("mr_ir", bus.id_ir, NOP);
        check_eq("mr_npc", bus.id_npc, 32'd0);
        check_eq("mr_pc", 32'(pc_out), 32'd0);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        check_eq("mr_req", 32'(bus.imem_req), 32'd1);
        tick();
        check_eq("mr_late", 32'(occupancy), 32'd0);
        tick();
        expect_head("mr_s0", 0);
        tick();
        expect_head("mr_s1", 1);

        // fetch_en low: no issue, queued entry still drains
        fetch_en = 1'b0;
        #1;
        check_eq("fe_req", 32'(bus.imem_req), 32'd0);
        tick();
        expect_head("fe_s2", 2);
        tick();
        check_eq("fe_empty", 32'(bus.id_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
